// File: rtl/reset_pkg.sv
// ---------------------------------------------------------------------------
// reset_pkg
// Shared definitions for the reset sequencer:
//   state_t  - sequencer states (SYNC, STRETCH, RELEASE, RUN)
//   bits_for - number of bits needed to hold a non-negative value (min 1)
// ---------------------------------------------------------------------------
package reset_pkg;

  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    STRETCH = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } state_t;

  // Width of a register that must hold values 0..max_val.
  function automatic int bits_for(input int max_val);
    int w;
    w = 1;
    while ((1 << w) <= max_val) w++;
    return w;
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// ---------------------------------------------------------------------------
// reset_sequencer_if
// Bundles the domain reset outputs of the sequencer.
//   rst_n      [CHANNELS]  active-low domain resets, bit 0 released first
//   done                   all domains released
//   sw_rst_req             software reset request (only when
//                          RESET_SEQUENCER_SW_RESET_EN is defined)
// master: the sequencer; slave: the consumer of the resets.
// ---------------------------------------------------------------------------
interface reset_sequencer_if #(
  parameter int CHANNELS = 3
);
  logic [CHANNELS-1:0] rst_n;
  logic                done;
`ifdef RESET_SEQUENCER_SW_RESET_EN
  logic                sw_rst_req;

  modport master (output rst_n, output done, input  sw_rst_req);
  modport slave  (input  rst_n, input  done, output sw_rst_req);
`else
  modport master (output rst_n, output done);
  modport slave  (input  rst_n, input  done);
`endif
endinterface

// File: rtl/reset_sync_chain.sv
// ---------------------------------------------------------------------------
// reset_sync_chain
// Reset-release synchronizer: clears asynchronously on rst, then shifts in
// ones so the output rises STAGES clock edges after rst drops.
//   clk   in   clock
//   rst   in   asynchronous active-high clear
//   q     out  synchronized "reset released" flag (last stage)
// ---------------------------------------------------------------------------
module reset_sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain <= '0;
    else     chain <= {chain[STAGES-2:0], 1'b1};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// ---------------------------------------------------------------------------
// reset_sequencer
// Synchronizes an asynchronous active-high reset, stretches it by
// STRETCH_CYCLES and releases CHANNELS active-low reset domains in order,
// STAGGER_CYCLES apart.
//   clk       in   system clock
//   asyncrst  in   asynchronous active-high reset (async assert, sync release)
//   bus       master modport of reset_sequencer_if (rst_n, done, sw_rst_req)
// Optional feature macro: RESET_SEQUENCER_SW_RESET_EN adds the software
// reset request, which re-runs stretch and release without touching the
// input synchronizer.
// ---------------------------------------------------------------------------
module reset_sequencer
  import reset_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int CHANNELS       = 3,
  parameter int STRETCH_CYCLES = 16,
  parameter int STAGGER_CYCLES = 4
) (
  input  logic              clk,
  input  logic              asyncrst,
  reset_sequencer_if.master bus
);

  localparam int CNT_MAX = (STRETCH_CYCLES > STAGGER_CYCLES) ? STRETCH_CYCLES
                                                             : STAGGER_CYCLES;
  localparam int CNT_W   = bits_for(CNT_MAX);
  localparam int IDX_W   = bits_for(CHANNELS - 1);

  localparam logic [CNT_W-1:0] STRETCH_LD = CNT_W'(STRETCH_CYCLES);
  localparam logic [CNT_W-1:0] STAGGER_LD = CNT_W'(STAGGER_CYCLES);

  logic                sync_out;
  state_t              state_q, state_nxt;
  logic [CNT_W-1:0]    cnt_q, cnt_nxt;
  logic [IDX_W-1:0]    idx_q, idx_nxt;
  logic [CHANNELS-1:0] rst_n_q, rst_n_nxt;
  logic                done_q, done_nxt;

  reset_sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (asyncrst),
    .q   (sync_out)
  );

  always_ff @(posedge clk or posedge asyncrst) begin
    if (asyncrst) begin
      state_q <= SYNC;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_n_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      idx_q   <= idx_nxt;
      rst_n_q <= rst_n_nxt;
      done_q  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    idx_nxt   = idx_q;
    rst_n_nxt = rst_n_q;
    done_nxt  = done_q;

    unique case (state_q)
      SYNC: begin
        if (sync_out) begin
          state_nxt = STRETCH;
          cnt_nxt   = STRETCH_LD;
        end
      end

      // The zero-count edge is part of the stretch, so the first release
      // lands STRETCH_CYCLES+1 edges after the load.
      STRETCH: begin
        if (cnt_q != '0) begin
          cnt_nxt = cnt_q - CNT_W'(1);
        end else begin
          idx_nxt = '0;
          if (STAGGER_CYCLES == 0 || CHANNELS == 1) begin
            rst_n_nxt = '1;
            done_nxt  = 1'b1;
            state_nxt = RUN;
          end else begin
            rst_n_nxt = CHANNELS'(1);
            cnt_nxt   = STAGGER_LD;
            state_nxt = RELEASE;
          end
        end
      end

      // Releases are exactly STAGGER_CYCLES apart: the edge that would take
      // the counter from 1 to 0 releases the next channel instead.
      RELEASE: begin
        if (cnt_q > CNT_W'(1)) begin
          cnt_nxt = cnt_q - CNT_W'(1);
        end else begin
          idx_nxt   = idx_q + IDX_W'(1);
          rst_n_nxt = CHANNELS'({rst_n_q, 1'b1});
          cnt_nxt   = STAGGER_LD;
          if (rst_n_nxt[CHANNELS-1]) begin
            done_nxt  = 1'b1;
            cnt_nxt   = '0;
            state_nxt = RUN;
          end
        end
      end

      RUN: ;

      default: state_nxt = SYNC;
    endcase

`ifdef RESET_SEQUENCER_SW_RESET_EN
    // Software restart re-enters the stretch; the synchronizer is untouched.
    if (bus.sw_rst_req && state_q != SYNC) begin
      state_nxt = STRETCH;
      cnt_nxt   = STRETCH_LD;
      idx_nxt   = '0;
      rst_n_nxt = '0;
      done_nxt  = 1'b0;
    end
`endif
  end

  assign bus.rst_n = rst_n_q;
  assign bus.done  = done_q;

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Parametrised reset generator for the FPGA fabric: synchronises an asynchronous, active-high reset input, stretches it to a minimum width and releases several active-low reset domains in a fixed order with a configurable stagger. An optional software reset request re-runs the stretch and release sequence without touching the input synchronizer. It sits at the top level between the board reset pin or PLL lock logic and the per-subsystem reset inputs.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth; at least 2.
- `CHANNELS`, 3: number of reset domains; at least 1.
- `STRETCH_CYCLES`, 16: extra low cycles before the first release; 0 allowed.
- `STAGGER_CYCLES`, 4: cycles between consecutive channel releases; 0 releases all channels together.

- `clk`  in  1  single system clock.
- `asyncrst`  in  1  asynchronous, active-high reset; asserts asynchronously, releases synchronously through the synchronizer.
- `sw_rst_req`  in  1  synchronous software reset request, sampled on `clk`; present only with the macro.
- `rst_n`  out  CHANNELS  active-low domain resets; bit 0 releases first.
- `done`  out  1  high when all channels are released.

## Operation
- States:
  - SYNC: waiting for the synchronizer output.
  - STRETCH: counter running.
  - RELEASE: channels released one by one.
  - RUN: all released.
- `asyncrst` high:
  - All flops clear asynchronously.
  - State goes to SYNC, all `rst_n` bits go to 0, `done` goes to 0.
  - The synchronizer chain fills with 0.
- SYNC to STRETCH: on the first edge where the synchronizer output is high. That edge loads the counter with `STRETCH_CYCLES`.
- STRETCH:
  - Each edge with the counter nonzero decrements it.
  - The edge with the counter at 0 sets `rst_n[0]`, loads the counter with `STAGGER_CYCLES` and enters RELEASE.
  - With `CHANNELS`=1, that same edge enters RUN.
- RELEASE:
  - The channel index increments each time the counter expires, and the next `rst_n` bit is set.
  - Setting `rst_n[CHANNELS-1]` also sets `done` and enters RUN.
  - With `STAGGER_CYCLES`=0, all bits are set on the same edge as `rst_n[0]`.
- Released bits stay high until the next reset event.
- The counter is sized to hold `max(STRETCH_CYCLES, STAGGER_CYCLES)`. It never wraps; a decrement happens only when the counter is nonzero.

## Timing
- Reset values: `rst_n`=0, `done`=0, state=SYNC, counter=0, channel index=0.
- Assertion latency: from `asyncrst` rising to `rst_n`=0 is combinational through async clear, with zero cycles.
- Release: let edge 1 be the first `clk` rising edge with `asyncrst` low.
  - `rst_n[i]` rises after edge `SYNC_STAGES+STRETCH_CYCLES+2+i*STAGGER_CYCLES`.
  - `done` rises with `rst_n[CHANNELS-1]`.
- Software reset (`sw_rst_req` sampled high at edge E, any state except SYNC):
  - After edge E: all `rst_n`=0, `done`=0, counter loaded with `STRETCH_CYCLES`, state STRETCH.
  - `rst_n[i]` rises after edge `E+STRETCH_CYCLES+1+i*STAGGER_CYCLES`.
- `sw_rst_req` held high keeps reloading the counter, so outputs stay low until one edge after it drops.
- `sw_rst_req` in SYNC is ignored.
- `sw_rst_req` during STRETCH or RELEASE restarts the sequence and re-asserts any channels already released.
- `asyncrst` asserted mid-sequence or in RUN forces an immediate full restart from SYNC. It has priority over `sw_rst_req`.

## Configuration
- `RESET_SEQUENCER_SW_RESET_EN`:
  - Defined: the `sw_rst_req` port and its restart logic exist as specified above.
  - Undefined: the port is absent, and the only path back to reset is `asyncrst`.

## Structure
- Shared package `reset_pkg` holds:
  - the state enum typedef (SYNC, STRETCH, RELEASE, RUN);
  - a width helper constant function for the counter and the channel index.
- Sub-module `reset_sync_chain`:
  - parameter `STAGES`;
  - async active-high clear;
  - shifts in 1 and outputs the last stage;
  - instantiated once.

## Test plan
All defaults unless noted (`SYNC_STAGES`=2, `CHANNELS`=3, `STRETCH_CYCLES`=16, `STAGGER_CYCLES`=4).
- **Power-up:** `asyncrst` high for 5 cycles, then low before edge 1. `rst_n[0]` rises after edge 20, `rst_n[1]` after edge 24, `rst_n[2]` after edge 28; `done` rises after edge 28.
- **Mid-sequence async reset:** `asyncrst` re-asserted at edge 22, between clock edges. `rst_n` reads 3'b000 immediately with no clock, `done`=0. After release, the full sequence repeats with edge 1 redefined.
- **Software reset in RUN:** `sw_rst_req` pulsed for one cycle at edge E. All `rst_n`=0 after E; `rst_n[0]` rises at E+17, `rst_n[1]` at E+21, `rst_n[2]` at E+25.
- **Held software reset:** `sw_rst_req` high for 40 cycles, then low before edge F. Outputs stay 0 throughout; `rst_n[0]` rises after edge F+16.
- **Degenerate parameters:** `STRETCH_CYCLES`=0, `STAGGER_CYCLES`=0, `CHANNELS`=1. `rst_n` and `done` both rise after edge 4.
- **Priority:** `sw_rst_req` and `asyncrst` asserted in the same cycle. The async path wins, the state goes to SYNC and the software request has no effect.
